sum_result_buffer: RTL and testbench

Downstream consumer of the registered adder stage's `valid`/`y` result pulse. It captures every result into a small FIFO and re-presents results on a valid/ready output handshake, so a back-pressured sink never loses a sum while space remains. It keeps a running accumulator of all results popped by the sink. Overflow is reported through a sticky flag and a saturating drop counter.

---
 rtl/sum_result_buffer.sv | 126 ++++++++++++
 tb/tb_sum_result_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_result_buffer.sv
// sum_result_buffer: captures every adder result into a small FIFO, re-presents
// results on a valid/ready handshake, accumulates every popped result and
// reports overflow through a sticky flag plus a saturating drop counter.
module sum_result_buffer #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    parameter int ACC_W = 32,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [ACC_W-1:0] acc,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    logic do_pop;
    logic do_push;
    logic do_drop;

    // Status flags come straight from the registered occupancy.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_data  = mem[rptr];

    // Handshake decode; clr suppresses every state-changing action.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        do_pop  = 1'b0;
        do_push = 1'b0;
        do_drop = 1'b0;
        if (!clr) begin
            do_pop = out_valid && out_ready;
            if (in_valid) begin
                // A pop in the same cycle frees the slot the new entry takes.
                if (!full || do_pop) begin
                    do_push = 1'b1;
                end else begin
                    do_drop = 1'b1;
                end
            end
        end
    end

    // Storage array: written at wptr on every accepted push; cleared only by reset.
    // NOTE: the array is reset so out_data reads 0 after reset; clr leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wptr] <= in_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Running sum of popped entries; wraps modulo 2^ACC_W by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (do_pop) begin
            acc <= acc + ACC_W'(out_data);
        end
    end

    // Overflow reporting: sticky flag plus drop counter that holds at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (do_drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sum_result_buffer.sv
// Testbench for sum_result_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based reference model. A second instance with
// ACC_W = W exercises accumulator wrap-around on the same stimulus.
module tb_sum_result_buffer;

    localparam int W     = 20;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          clr;
    logic          out_ready;

    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [31:0]   acc;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [7:0]    drop_cnt;

    logic          w_out_valid;
    logic [W-1:0]  w_out_data;
    logic [W-1:0]  w_acc;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_overflow;
    logic [7:0]    w_drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0]    q[$];
    longint unsigned m_acc;
    logic            m_ovf;
    int              m_drops;

    sum_result_buffer #(.W(W), .DEPTH(DEPTH), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .acc(acc), .count(count), .full(full),
        .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    sum_result_buffer #(.W(W), .DEPTH(DEPTH), .ACC_W(W)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .clr(clr), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .acc(w_acc), .count(w_count), .full(w_full),
        .empty(w_empty), .overflow(w_overflow), .drop_cnt(w_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_acc   = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // One clock of the reference model, from the rules of the block.
    task automatic model_step(input logic iv, input logic [W-1:0] d, input logic rdy, input logic c);
        bit popping;
        if (c) begin
            model_clear();
            return;
        end
        popping = rdy && (q.size() > 0);
        if (popping) begin
            m_acc = m_acc + longint'(q[0]);
            void'(q.pop_front());
        end
        if (iv) begin
            if (q.size() < DEPTH) begin
                q.push_back(d);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] e_acc32;
        logic [63:0] e_acc20;
        e_acc32 = m_acc & 64'hFFFF_FFFF;
        e_acc20 = m_acc & 64'hF_FFFF;
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) check({tag, ".out_data"}, 64'(out_data), 64'(q[0]));
        check({tag, ".count"},    64'(count),    64'(q.size()));
        check({tag, ".full"},     64'(full),     64'(q.size() == DEPTH));
        check({tag, ".empty"},    64'(empty),    64'(q.size() == 0));
        check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drops));
        check({tag, ".acc"},      64'(acc),      e_acc32);
        check({tag, ".acc_w"},    64'(w_acc),    e_acc20);
        check({tag, ".w_count"},  64'(w_count),  64'(q.size()));
    endtask

    // Drive one cycle of inputs, advance model and DUT, then check on the falling edge.
    task automatic step(input string tag, input logic iv, input logic [W-1:0] d,
                        input logic rdy, input logic c);
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        clr       = c;
        model_step(iv, d, rdy, c);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        clr       = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);

        // Reset values, including the zeroed array on out_data
        check("rst.out_data", 64'(out_data), 64'h0);
        check_all("rst");
        rst_n = 1'b1;

        // Single result
        step("single.push", 1'b1, 20'h00123, 1'b1, 1'b0);
        check("single.data", 64'(out_data), 64'h123);
        step("single.pop", 1'b0, 20'h0, 1'b1, 1'b0);
        check("single.acc", 64'(acc), 64'h123);

        // Fill and drop
        step("fd.clr", 1'b0, 20'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step("fd.push", 1'b1, 20'(i), 1'b0, 1'b0);
        check("fd.drop_cnt", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 4; i++) step("fd.pop", 1'b0, 20'h0, 1'b1, 1'b0);
        check("fd.acc", 64'(acc), 64'd10);

        // Full with simultaneous push/pop
        step("fs.clr", 1'b0, 20'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) step("fs.fill", 1'b1, 20'(i), 1'b0, 1'b0);
        step("fs.pushpop", 1'b1, 20'd9, 1'b1, 1'b0);
        check("fs.nodrop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 4; i++) step("fs.drain", 1'b0, 20'h0, 1'b1, 1'b0);

        // Accumulator wrap on the ACC_W = W instance
        step("wrap.clr", 1'b0, 20'h0, 1'b0, 1'b1);
        step("wrap.p1", 1'b1, 20'hFFFFF, 1'b0, 1'b0);
        step("wrap.p2", 1'b1, 20'h00002, 1'b0, 1'b0);
        step("wrap.pop1", 1'b0, 20'h0, 1'b1, 1'b0);
        step("wrap.pop2", 1'b0, 20'h0, 1'b1, 1'b0);
        check("wrap.acc_w", 64'(w_acc), 64'h00001);

        // Clear priority: count 3, overflow set, 7 drops
        step("cp.clr", 1'b0, 20'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("cp.fill", 1'b1, 20'(i + 16), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step("cp.drop", 1'b1, 20'h777, 1'b0, 1'b0);
        step("cp.pop", 1'b0, 20'h0, 1'b1, 1'b0);
        check("cp.pre_drops", 64'(drop_cnt), 64'd7);
        step("cp.clear", 1'b1, 20'h1234, 1'b1, 1'b1);
        check("cp.empty", 64'(empty), 64'd1);
        step("cp.after", 1'b0, 20'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation
        step("ar.p1", 1'b1, 20'h00011, 1'b0, 1'b0);
        step("ar.p2", 1'b1, 20'h00022, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_clear();
        #1 check_all("ar.async");
        check("ar.out_data", 64'(out_data), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("ar.push55", 1'b1, 20'h00055, 1'b0, 1'b0);
        check("ar.data55", 64'(out_data), 64'h55);

        // Drop counter saturation
        for (int i = 0; i < 3; i++) step("sat.fill", 1'b1, 20'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step("sat.drop", 1'b1, 20'hABCDE, 1'b0, 1'b0);
        check("sat.drop_cnt", 64'(drop_cnt), 64'd255);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step("rnd", 1'($urandom_range(0, 99) < 70), 20'($urandom),
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
